// File: rtl/tcb_gpio_irq.sv
// GPIO interrupt stage: per-pin rising/falling edge detection into a sticky
// pending register, masked into one registered level interrupt. Configured
// and serviced through a TCB subordinate port (RISE/FALL/PEND/MASK).
module tcb_gpio_irq #(
  parameter int unsigned GW = 32,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [GW-1:0] gpio_r,
  output logic          irq,
  input  logic          bus_vld,
  input  logic          bus_wen,
  input  logic [AW-1:0] bus_adr,
  input  logic [31:0]   bus_wdt,
  output logic [31:0]   bus_rdt,
  output logic          bus_rdy,
  output logic          bus_err
);

  typedef enum logic [1:0] {
    REG_RISE = 2'd0,
    REG_FALL = 2'd1,
    REG_PEND = 2'd2,
    REG_MASK = 2'd3
  } reg_sel_e;

  logic [GW-1:0] rise_en_q, rise_en_d;
  logic [GW-1:0] fall_en_q, fall_en_d;
  logic [GW-1:0] pend_q, pend_d;
  logic [GW-1:0] mask_q, mask_d;
  logic [GW-1:0] prev_q, prev_d;
  logic          irq_q, irq_d;
  logic [31:0]   rdt_q, rdt_d;
  logic          init_q, init_d;

  logic          adr_bad_s;
  logic          wr_s;
  logic          rd_s;
  reg_sel_e      sel_s;
  logic [GW-1:0] wdt_s;
  logic [GW-1:0] w1c_s;
  logic [GW-1:0] evt_s;
  logic [31:0]   rd_val_s;

  assign bus_rdy = 1'b1;
  assign bus_err = bus_vld & adr_bad_s;
  assign irq     = irq_q;
  assign bus_rdt = rdt_q;

  // Address decode: only word-aligned offsets 0x0..0xC are mapped.
  always_comb begin
    adr_bad_s = (bus_adr[1:0] != 2'd0) || ((bus_adr >> 4) != {AW{1'b0}});
    sel_s     = reg_sel_e'(bus_adr[3:2]);
    wr_s      = bus_vld & bus_wen & ~adr_bad_s;
    rd_s      = bus_vld & ~bus_wen;
    wdt_s     = bus_wdt[GW-1:0];
  end

  // Read mux of current (pre-update) register values, zero-extended to 32 bits.
  always_comb begin
    rd_val_s = 32'd0;
    case (sel_s)
      REG_RISE: rd_val_s[GW-1:0] = rise_en_q;
      REG_FALL: rd_val_s[GW-1:0] = fall_en_q;
      REG_PEND: rd_val_s[GW-1:0] = pend_q;
      REG_MASK: rd_val_s[GW-1:0] = mask_q;
      default:  rd_val_s = 32'd0;
    endcase
  end

  // Next-state: register writes, edge detection, pending set/clear, irq.
  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    mask_d    = mask_q;
    w1c_s     = {GW{1'b0}};
    rdt_d     = rdt_q;
    init_d    = 1'b1;
    prev_d    = gpio_r;

    if (wr_s) begin
      case (sel_s)
        REG_RISE: rise_en_d = wdt_s;
        REG_FALL: fall_en_d = wdt_s;
        REG_PEND: w1c_s     = wdt_s;
        REG_MASK: mask_d    = wdt_s;
        default:  w1c_s     = {GW{1'b0}};
      endcase
    end else begin
      w1c_s = {GW{1'b0}};
    end

    if (rd_s) begin
      rdt_d = adr_bad_s ? 32'd0 : rd_val_s;
    end else begin
      rdt_d = rdt_q;
    end

    // The first cycle after reset has no valid history in prev_q.
    if (init_q) begin
      evt_s = (gpio_r & ~prev_q & rise_en_q) | (~gpio_r & prev_q & fall_en_q);
    end else begin
      evt_s = {GW{1'b0}};
    end

    // Set wins over a same-cycle W1C on the same bit.
    pend_d = (pend_q & ~w1c_s) | evt_s;
    irq_d  = |(pend_d & mask_d);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_en_q <= {GW{1'b0}};
      fall_en_q <= {GW{1'b0}};
      pend_q    <= {GW{1'b0}};
      mask_q    <= {GW{1'b0}};
      prev_q    <= {GW{1'b0}};
      irq_q     <= 1'b0;
      rdt_q     <= 32'd0;
      init_q    <= 1'b0;
    end else begin
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      prev_q    <= prev_d;
      irq_q     <= irq_d;
      rdt_q     <= rdt_d;
      init_q    <= init_d;
    end
  end

endmodule

// File: doc/tcb_gpio_irq.md
Name: tcb_gpio_irq

Overview:
- Interrupt stage downstream of the GPIO controller's input path. Consumes the already-synchronized GPIO input vector, detects per-pin rising and falling edges, and latches events into a pending register.
- Drives a single registered level interrupt to the CPU.
- Configured and serviced through its own TCB subordinate port, alongside the GPIO controller on the peripheral bus.

Parameters:
- GW, 32, GPIO width (1..32).
- AW, 4, decoded address bits (byte address; bits [AW-1:0] decoded).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- gpio_r  in  GW  synchronized GPIO input (no CDC inside this block)
- irq  out  1  interrupt request, level, registered
- bus_vld  in  1  TCB transfer valid
- bus_wen  in  1  TCB write enable (1 = write, 0 = read)
- bus_adr  in  AW  TCB byte address
- bus_wdt  in  32  TCB write data
- bus_rdt  out  32  TCB read data, valid one cycle after the transfer
- bus_rdy  out  1  TCB ready
- bus_err  out  1  TCB error

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state resets to 0: rise_en, fall_en, pending, mask, prev, irq, bus_rdt, init.
- Handshake:
  - bus_rdy is constant 1. A transfer occurs when bus_vld is high.
  - bus_err = 1 only for an access to an address outside 0x0/0x4/0x8/0xC (adr[1:0] != 0 or unmapped). bus_err is combinational, in the same cycle as the transfer.
- Register map (unused upper bits read 0):
  - 0x0 RISE: per-bit rising-edge enable, RW.
  - 0x4 FALL: per-bit falling-edge enable, RW.
  - 0x8 PEND: pending events. A read returns pending. A write is W1C: bits written 1 clear, bits written 0 are unchanged.
  - 0xC MASK: per-bit interrupt enable, RW.
- Read timing:
  - bus_rdt is registered with 1-cycle latency and is updated only on a read transfer. It holds its value otherwise.
  - An unmapped read loads 0.
  - A read returns the register value from before any same-cycle update.
- Edge detection:
  - prev <= gpio_r every cycle.
  - rise = gpio_r & ~prev & rise_en.
  - fall = ~gpio_r & prev & fall_en.
  - event = rise | fall.
- Post-reset suppression:
  - The init flag is 0 out of reset and becomes 1 after the first cycle.
  - While init = 0, event is forced to 0, so a pin high at reset release creates no spurious rising edge.
- Pending update each cycle: pending <= (pending & ~w1c_mask) | event.
  - w1c_mask is bus_wdt only during a write to 0x8, otherwise 0.
  - If a W1C and an event hit the same bit in the same cycle, set wins and the bit stays 1.
- Enable changes:
  - Writing RISE or FALL takes effect in the next cycle's detection.
  - Existing pending bits are not cleared by disabling detection.
- Interrupt: irq <= |(pending_next & mask_next).
  - irq asserts 1 cycle after the event cycle.
  - irq deasserts 1 cycle after the clearing W1C or mask write.
- Events are sticky single-bit flags. Multiple edges before clearing collapse into one pending bit; they are not counted.
- A reset asserted mid-operation clears everything on the next clk edge. Any in-flight read data is lost, and bus_rdt becomes 0.

Test Plan:
- Reset release with gpio_r = 0xFFFF_FFFF and RISE = all ones written right after reset → PEND reads 0x0 and irq stays 0.
- Write RISE = 0x1, MASK = 0x1; drive gpio_r[0] 0→1 at cycle N → PEND bit0 = 1 at N+1, irq = 1 at N+1; a read of 0x8 returns 0x1 on bus_rdt one cycle after the request.
- FALL = 0x80, MASK = 0x0; toggle gpio_r[7] 1→0 → PEND = 0x80 while irq stays 0; then write MASK = 0x80 → irq = 1 the next cycle.
- PEND = 0x3; write 0x8 with wdt = 0x1 in the same cycle as a new rising edge on bit0 → PEND = 0x3 (set wins); then write wdt = 0x3 with no edge → PEND = 0x0 and irq = 0 the next cycle.
- Read 0x10 or 0x2 → bus_err = 1 in the same cycle; bus_rdt = 0 on the next cycle; no register changes.
- Three rising edges on bit 4 with no clear → PEND = 0x10 (a single flag); assert rst mid-stream → all registers, irq, and bus_rdt read 0 after the reset edge.
